uart_tx_frame_gen: RTL and testbench

//  Periodic frame source feeding the rs232_top transmit side (i_tx_dat/i_tx_en/o_tx_over).

---
 rtl/uart_tx_frame_gen_if.sv | 10 +
 rtl/uart_tx_frame_gen.sv | 139 +++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_gen_if.sv
// Byte handshake between the frame generator and the UART transmitter.
// The frame generator drives data/enable; the UART returns a byte-done pulse.
interface uart_tx_frame_gen_if;
   logic [7:0] o_tx_dat;
   logic       o_tx_en;
   logic       i_tx_over;

   modport master (output o_tx_dat, output o_tx_en, input  i_tx_over);
   modport slave  (input  o_tx_dat, input  o_tx_en, output i_tx_over);
endinterface

// File: rtl/uart_tx_frame_gen.sv
// Periodic frame source for a UART transmitter: HEADER, SEQ, PAY_LEN payload, CHECKSUM.
// One byte in flight at a time, with a per-byte watchdog on the UART's done pulse.
module uart_tx_frame_gen #(
   parameter int unsigned PERIOD  = 2000,
   parameter int unsigned PAY_LEN = 4,
   parameter logic [7:0]  HEADER  = 8'hA5,
   parameter int unsigned TIMEOUT = 20000
) (
   input  logic                clk_ref,
   input  logic                rst_n,
   input  logic                i_start_en,
   input  logic                i_err_clr,
   uart_tx_frame_gen_if.master tx,
   output logic                o_busy,
   output logic                o_frame_done,
   output logic                o_timeout_err
);
   localparam int GW = $clog2(PERIOD);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [GW-1:0] GAP_END  = GW'(PERIOD - 1);
   localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT - 1);
   localparam logic [8:0]    LAST_IDX = 9'(PAY_LEN + 2);

   typedef enum logic [2:0] {IDLE, GAP, SEND, WAIT, DONE} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt, tmo_inc;
   logic [8:0]    idx, idx_nxt;
   logic [7:0]    seq, seq_nxt;
   logic [7:0]    chk, chk_nxt;
   logic [7:0]    dat_nxt;
   logic          err_nxt;
   logic          load;

   assign tmo_inc = tmo_cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      gap_nxt   = gap_cnt;
      tmo_nxt   = tmo_cnt;
      idx_nxt   = idx;
      seq_nxt   = seq;
      chk_nxt   = chk;
      dat_nxt   = tx.o_tx_dat;
      err_nxt   = o_timeout_err;
      load      = 1'b0;

      // clear first so a same-clock expiry below overrides it
      if (i_err_clr) err_nxt = 1'b0;

      case (state)
         IDLE: begin
            gap_nxt = '0;
            if (i_start_en) state_nxt = GAP;
         end
         GAP: begin
            if (!i_start_en) begin
               state_nxt = IDLE;
               gap_nxt   = '0;
            end else if (gap_cnt == GAP_END) begin
               state_nxt = SEND;
               gap_nxt   = '0;
               idx_nxt   = '0;
               load      = 1'b1;
            end else begin
               gap_nxt = gap_cnt + 1'b1;
            end
         end
         SEND: begin
            state_nxt = WAIT;
            tmo_nxt   = '0;
         end
         WAIT: begin
            tmo_nxt = tmo_inc;
            // byte-done takes priority over a watchdog expiry in the same clock
            if (tx.i_tx_over) begin
               if (idx == LAST_IDX) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SEND;
                  idx_nxt   = idx + 1'b1;
                  load      = 1'b1;
               end
            end else if (tmo_inc == TMO_END) begin
               state_nxt = IDLE;
               tmo_nxt   = '0;
               err_nxt   = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            seq_nxt   = seq + 8'd1;
         end
         default: state_nxt = IDLE;
      endcase

      // pick the byte for the upcoming SEND and fold it into the running checksum
      if (load) begin
         if (idx_nxt == 9'd0) begin
            dat_nxt = HEADER;
            chk_nxt = '0;
         end else if (idx_nxt == LAST_IDX) begin
            dat_nxt = chk;
         end else begin
            dat_nxt = (idx_nxt == 9'd1) ? seq : seq + idx_nxt[7:0] - 8'd2;
            chk_nxt = chk + dat_nxt;
         end
      end
   end

   always_ff @(posedge clk_ref) begin
      if (!rst_n) begin
         state         <= IDLE;
         gap_cnt       <= '0;
         tmo_cnt       <= '0;
         idx           <= '0;
         seq           <= '0;
         chk           <= '0;
         tx.o_tx_dat   <= '0;
         tx.o_tx_en    <= 1'b0;
         o_busy        <= 1'b0;
         o_frame_done  <= 1'b0;
         o_timeout_err <= 1'b0;
      end else begin
         state         <= state_nxt;
         gap_cnt       <= gap_nxt;
         tmo_cnt       <= tmo_nxt;
         idx           <= idx_nxt;
         seq           <= seq_nxt;
         chk           <= chk_nxt;
         tx.o_tx_dat   <= dat_nxt;
         tx.o_tx_en    <= (state_nxt == SEND);
         o_busy        <= (state_nxt == SEND) || (state_nxt == WAIT) || (state_nxt == DONE);
         o_frame_done  <= (state_nxt == DONE);
         o_timeout_err <= err_nxt;
      end
   end
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench: expected bytes are queued ahead of each frame and popped by a
// monitor on every o_tx_en; a UART model answers each byte after a programmable delay.
module tb_uart_tx_frame_gen;
   localparam int PER = 20;
   localparam int PL  = 4;
   localparam int TMO = 40;

   logic clk_ref = 1'b0;
   logic rst_n = 1'b0, start_en = 1'b0, err_clr = 1'b0;
   logic busy, frame_done, timeout_err;
   logic uart_over = 1'b0, stray_over = 1'b0;

   uart_tx_frame_gen_if u_if();
   assign u_if.i_tx_over = uart_over | stray_over;

   uart_tx_frame_gen #(.PERIOD(PER), .PAY_LEN(PL), .HEADER(8'hA5), .TIMEOUT(TMO)) dut (
      .clk_ref(clk_ref), .rst_n(rst_n), .i_start_en(start_en), .i_err_clr(err_clr),
      .tx(u_if.master), .o_busy(busy), .o_frame_done(frame_done), .o_timeout_err(timeout_err));

   always #5 clk_ref = ~clk_ref;

   int cyc = 0;
   always @(posedge clk_ref) cyc <= cyc + 1;

   // UART model: byte-done pulse uart_dly clocks after o_tx_en, except byte number drop_at
   int uart_dly = 10, uart_en_cnt = 0, drop_at = -1, ucnt = 0;
   initial forever begin
      @(negedge clk_ref);
      uart_over = 1'b0;
      if (!rst_n) ucnt = 0;
      else begin
         if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) uart_over = 1'b1;
         end
         if (u_if.o_tx_en) begin
            uart_en_cnt++;
            if (uart_en_cnt != drop_at) ucnt = uart_dly;
         end
      end
   end

   int n_cmp = 0, n_err = 0;
   logic [7:0] exp_q[$];
   int en_cyc[$];
   int done_cnt = 0, en_total = 0, err_rise = -1;
   logic err_d = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk_ref);
         if (u_if.o_tx_en) begin
            en_total++;
            en_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL tx_byte: unexpected o_tx_en with 0x%02h, nothing queued (cycle %0d)",
                        u_if.o_tx_dat, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", {24'd0, u_if.o_tx_dat}, {24'd0, e});
            end
         end
         if (frame_done) done_cnt++;
         if (timeout_err && !err_d) err_rise = cyc;
         err_d = timeout_err;
      end
   endtask

   task automatic push_bytes(input logic [55:0] v);
      for (int i = 0; i < 7; i++) exp_q.push_back(v[55-8*i -: 8]);
   endtask

   task automatic push_frame(input int s);
      logic [7:0] sq, ck, p;
      sq = s[7:0];
      ck = sq;
      exp_q.push_back(8'hA5);
      exp_q.push_back(sq);
      for (int k = 0; k < PL; k++) begin
         p = sq + k[7:0];
         exp_q.push_back(p);
         ck = ck + p;
      end
      exp_q.push_back(ck);
   endtask

   task automatic wait_done(input int target, input int budget, input string nm);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk_ref);
         n++;
      end
      chk(nm, done_cnt, target);
   endtask

   task automatic wait_en(input int target, input int budget);
      int n = 0;
      while (en_cyc.size() < target && n < budget) begin
         @(negedge clk_ref);
         n++;
      end
   endtask

   int t1_first, n;

   initial begin
      fork monitor(); join_none

      // reset state
      repeat (3) @(negedge clk_ref);
      chk("rst_tx_en", u_if.o_tx_en, 0);
      chk("rst_tx_dat", u_if.o_tx_dat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", timeout_err, 0);
      rst_n = 1'b1;

      // T1: first frame, SEQ 00
      push_bytes(56'hA5_00_00_01_02_03_06);
      start_en = 1'b1;
      wait_done(1, 400, "t1_done");
      chk("t1_q_empty", exp_q.size(), 0);
      chk("t1_nbytes", en_cyc.size(), 7);
      t1_first = (en_cyc.size() > 0) ? en_cyc[0] : 0;
      en_cyc.delete();

      // T2: second frame, byte spacing and start-to-start period
      push_bytes(56'hA5_01_01_02_03_04_0B);
      wait_done(2, 400, "t2_done");
      chk("t2_nbytes", en_cyc.size(), 7);
      if (en_cyc.size() == 7) begin
         for (int i = 1; i < 7; i++) chk("t2_spacing", en_cyc[i] - en_cyc[i-1], 11);
         chk("t2_period", en_cyc[0] - t1_first, 7 * 11 + PER + 2);
      end

      // T3: run SEQ up to FF with a fast UART, then check the wrap
      uart_dly = 1;
      for (int s = 2; s < 255; s++) push_frame(s);
      wait_done(255, 20000, "t3_ff_done");
      uart_dly = 10;
      push_bytes(56'hA5_FF_FF_00_01_02_01);
      wait_done(256, 400, "t3_seqff_done");
      push_bytes(56'hA5_00_00_01_02_03_06);
      wait_done(257, 400, "t3_wrap_done");
      chk("t3_q_empty", exp_q.size(), 0);

      // T4: UART never finishes the 3rd byte -> watchdog
      en_cyc.delete();
      drop_at = uart_en_cnt + 3;
      push_frame(1);
      n = 0;
      while (err_rise < 0 && n < 600) begin
         @(negedge clk_ref);
         n++;
      end
      chk("t4_err_set", timeout_err, 1);
      chk("t4_nbytes", en_cyc.size(), 3);
      if (en_cyc.size() >= 3) chk("t4_err_latency", err_rise - en_cyc[2], TMO);
      chk("t4_left", exp_q.size(), 4);
      exp_q.delete();
      chk("t4_no_done", done_cnt, 257);
      chk("t4_idle", busy, 0);
      drop_at = -1;
      @(negedge clk_ref) err_clr = 1'b1;
      @(negedge clk_ref) err_clr = 1'b0;
      chk("t4_err_clr", timeout_err, 0);
      push_bytes(56'hA5_01_01_02_03_04_0B);
      wait_done(258, 400, "t4_seq_reuse_done");

      // T5: reset during WAIT of the 4th byte
      en_cyc.delete();
      push_frame(2);
      wait_en(4, 400);
      chk("t5_reach_byte4", en_cyc.size(), 4);
      repeat (3) @(negedge clk_ref);
      rst_n = 1'b0;
      @(negedge clk_ref);
      chk("t5_tx_en", u_if.o_tx_en, 0);
      chk("t5_tx_dat", u_if.o_tx_dat, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", frame_done, 0);
      chk("t5_err", timeout_err, 0);
      chk("t5_left", exp_q.size(), 3);
      exp_q.delete();
      @(negedge clk_ref) rst_n = 1'b1;
      push_bytes(56'hA5_00_00_01_02_03_06);
      wait_done(259, 400, "t5_restart_done");

      // T6: drop i_start_en mid-payload; frame still completes, then silence
      en_cyc.delete();
      push_frame(1);
      wait_en(3, 400);
      start_en = 1'b0;
      wait_done(260, 400, "t6_done");
      n = en_total;
      for (int i = 0; i < 3 * PER; i++) begin
         @(negedge clk_ref);
         stray_over = (i % 7 == 3);
      end
      stray_over = 1'b0;
      chk("t6_no_tx", en_total, n);
      chk("t6_no_done", done_cnt, 260);
      chk("t6_idle", busy, 0);
      start_en = 1'b1;
      push_frame(2);
      wait_done(261, 400, "t6_resume_done");

      // T7: byte-done lands on the watchdog expiry clock -> byte counts as sent
      uart_dly = TMO - 1;
      push_frame(3);
      wait_done(262, 7 * TMO + 200, "t7_done");
      chk("t7_no_err", timeout_err, 0);
      start_en = 1'b0;
      repeat (5) @(negedge clk_ref);
      chk("end_q_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
